seven_segment_scan_capture: RTL and testbench

- Receive-side counterpart of the seven-segment drive path.
- Samples a multiplexed segment bus (segment lines plus one-hot tube selects) and recovers the per-tube BCD digit.
- Holds the recovered digits in a register bank.
- Used for display loopback self-check and for capturing display state from the scanned display bus.

---
 rtl/seven_segment_scan_capture_if.sv | 43 ++++
 rtl/seven_segment_scan_capture.sv | 150 +++++++++++++++
 tb/tb_seven_segment_scan_capture.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scan_capture_if.sv
// Scanned seven-segment display bus as seen by the capture block.
// The master drives the segment lines and tube selects. The slave returns the
// recovered digits, the status pulses and a debug view of its stability state.
//
// Handshake: this bus has no valid/ready pair. seg_in and tub_sel_in are
// level signals, sampled on every rising clk edge. A {seg_in, tub_sel_in}
// pair counts as a transfer only once it has stayed unchanged long enough to
// be committed. frame_done and err are one-cycle registered pulses, and the
// receiver is expected to accept them unconditionally.
interface seven_segment_scan_capture_if #(
    parameter int NUM_DIGITS = 8
);
    logic [7:0]              seg_in;
    logic [NUM_DIGITS-1:0]   tub_sel_in;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    frame_done;
    logic                    err;
    logic [NUM_DIGITS-1:0]   dp_out;
    logic                    hold_dbg;

    modport master (
        output seg_in,
        output tub_sel_in,
        input  digits_out,
        input  digit_valid,
        input  frame_done,
        input  err,
        input  dp_out,
        input  hold_dbg
    );

    modport slave (
        input  seg_in,
        input  tub_sel_in,
        output digits_out,
        output digit_valid,
        output frame_done,
        output err,
        output dp_out,
        output hold_dbg
    );
endinterface

// File: rtl/seven_segment_scan_capture.sv
// seven_segment_scan_capture: recovers per-tube BCD digits from a multiplexed
// seven-segment bus. A {seg, sel} pair is committed once it has been seen
// unchanged on STABLE_CYCLES+1 consecutive edges. That rule filters scan
// glitches and short pulses.
// Optional build macro CAPTURE_DP_EN: when defined, the decimal point
// (seg_in[0]) is captured per tube into dp_out. When it is undefined, dp_out
// stays 0 and seg_in[0] is masked off before sampling, so it cannot disturb
// stability.
// State TRACK/HOLD is exposed on bus.hold_dbg (1 = HOLD).
module seven_segment_scan_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input logic clk,
    input logic rst,
    seven_segment_scan_capture_if.slave bus
);

    typedef enum logic {TRACK = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

`ifdef CAPTURE_DP_EN
    localparam logic [7:0] SEG_MASK = 8'hFF;
`else
    localparam logic [7:0] SEG_MASK = 8'hFE;
`endif

    // Returns {unrecognised, digit}. A blank tube decodes to F without error.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        case (pat)
            7'b1111110: decode_seg = {1'b0, 4'd0};
            7'b0110000: decode_seg = {1'b0, 4'd1};
            7'b1101101: decode_seg = {1'b0, 4'd2};
            7'b1111001: decode_seg = {1'b0, 4'd3};
            7'b0110011: decode_seg = {1'b0, 4'd4};
            7'b1011011: decode_seg = {1'b0, 4'd5};
            7'b1011111: decode_seg = {1'b0, 4'd6};
            7'b1110000: decode_seg = {1'b0, 4'd7};
            7'b1111111: decode_seg = {1'b0, 4'd8};
            7'b1111011: decode_seg = {1'b0, 4'd9};
            7'b0000000: decode_seg = {1'b0, 4'hF};
            default:    decode_seg = {1'b1, 4'hE};
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [7:0]              cur_seg_q;
    logic [NUM_DIGITS-1:0]   cur_sel_q;
    logic [7:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic                    frame_q, frame_d;
    logic                    err_q, err_d;

    logic [7:0]            seg_s;
    logic                  match;
    logic                  commit;
    logic                  sel_any;
    logic                  sel_multi;
    logic [4:0]            dec;
    logic [NUM_DIGITS-1:0] seen_next;

    assign seg_s     = bus.seg_in & SEG_MASK;
    assign match     = (seg_s == cur_seg_q) && (bus.tub_sel_in == cur_sel_q);
    assign commit    = match && (cnt_q == STABLE_MAX - 8'd1);
    assign sel_any   = |cur_sel_q;
    assign sel_multi = (cur_sel_q & (cur_sel_q - NUM_DIGITS'(1))) != '0;
    assign dec       = decode_seg(cur_seg_q[7:1]);

    // Next-state: stability counter, then commit decode into the digit bank.
    always_comb begin
        cnt_d     = cnt_q;
        state_d   = state_q;
        seen_d    = seen_q;
        digits_d  = digits_q;
        valid_d   = valid_q;
        dp_d      = dp_q;
        frame_d   = 1'b0;
        err_d     = 1'b0;
        seen_next = seen_q | cur_sel_q;

        if (!match) begin
            cnt_d = 8'd0;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
        state_d = (cnt_d == STABLE_MAX) ? HOLD : TRACK;

        if (commit && sel_any) begin
            if (sel_multi) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cur_sel_q[i]) begin
                        digits_d[4*i +: 4] = dec[3:0];
                        valid_d[i]         = 1'b1;
`ifdef CAPTURE_DP_EN
                        dp_d[i]            = cur_seg_q[0];
`endif
                    end
                end
                err_d = dec[4];
                if (seen_next == '1) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end else begin
                    seen_d = seen_next;
                end
            end
        end
    end

    // State, sample and output registers; async reset discards partial stability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TRACK;
            cur_seg_q <= 8'd0;
            cur_sel_q <= '0;
            cnt_q     <= 8'd0;
            seen_q    <= '0;
            digits_q  <= {NUM_DIGITS{4'hF}};
            valid_q   <= '0;
            dp_q      <= '0;
            frame_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_seg_q <= seg_s;
            cur_sel_q <= bus.tub_sel_in;
            cnt_q     <= cnt_d;
            seen_q    <= seen_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.dp_out      = dp_q;
    assign bus.frame_done  = frame_q;
    assign bus.err         = err_q;
    assign bus.hold_dbg    = (state_q == HOLD);

endmodule

// File: tb/tb_seven_segment_scan_capture.sv
// Bench for seven_segment_scan_capture: directed scenarios plus a randomized
// episode stream checked against a run-length reference model.
module tb_seven_segment_scan_capture;

    localparam int N = 8;
    localparam int S = 4;
`ifdef CAPTURE_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    seven_segment_scan_capture_if #(.NUM_DIGITS(N)) bus ();

    seven_segment_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    // Reference model. A value is committed when it has been present at
    // S+1 consecutive edges. Reset behaves like an edge that saw all zeros.
    logic [4*N-1:0] m_digits;
    logic [N-1:0]   m_valid, m_dp, m_seen;
    logic           m_err, m_frame;
    logic [8+N-1:0] m_prev;
    int             m_run;

    task automatic model_reset();
        m_digits = {N{4'hF}};
        m_valid  = '0;
        m_dp     = '0;
        m_seen   = '0;
        m_err    = 1'b0;
        m_frame  = 1'b0;
        m_prev   = '0;
        m_run    = 1;
    endtask

    task automatic model_edge(input logic [7:0] seg, input logic [N-1:0] sel);
        logic [8+N-1:0] key;
        logic [3:0]     d;
        bit             found;
        int             idx;
        key = {seg & (DP_EN ? 8'hFF : 8'hFE), sel};
        m_err   = 1'b0;
        m_frame = 1'b0;
        if (key == m_prev) m_run++;
        else begin
            m_run  = 1;
            m_prev = key;
        end
        if (m_run == S + 1 && $countones(sel) > 1) m_err = 1'b1;
        if (m_run == S + 1 && $countones(sel) == 1) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (sel[i]) idx = i;
            found = 1'b0;
            d = 4'hE;
            for (int k = 0; k < 10; k++) if (seg[7:1] == seg_tab[k]) begin
                found = 1'b1;
                d = 4'(k);
            end
            if (seg[7:1] == 7'b0) begin
                found = 1'b1;
                d = 4'hF;
            end
            m_err = !found;
            m_digits[4*idx +: 4] = d;
            m_valid[idx] = 1'b1;
            if (DP_EN) m_dp[idx] = seg[0];
            m_seen[idx] = 1'b1;
            if (m_seen == '1) begin
                m_frame = 1'b1;
                m_seen  = '0;
            end
        end
    endtask

    // Driver: present inputs at negedge, let one rising edge happen, sample 1ns later.
    task automatic drive_edge(input logic [7:0] seg, input logic [N-1:0] sel);
        @(negedge clk);
        bus.seg_in     = seg;
        bus.tub_sel_in = sel;
        @(posedge clk);
        model_edge(seg, sel);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.seg_in = 8'h00;
        bus.tub_sel_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_vec++;
        if (bus.digits_out !== {N{4'hF}}) begin
            n_err++; $display("FAIL reset_digits got=%h exp=%h", bus.digits_out, {N{4'hF}});
        end
        n_vec++;
        if ({bus.digit_valid, bus.dp_out, bus.err, bus.frame_done} !== '0) begin
            n_err++; $display("FAIL reset_flags valid=%h dp=%h err=%b frame=%b exp all 0",
                              bus.digit_valid, bus.dp_out, bus.err, bus.frame_done);
        end
    endtask

    task automatic test_commit_latency();
        for (int e = 0; e < 4; e++) drive_edge(8'b11111100, 8'h01);
        n_vec++;
        if (bus.digit_valid !== 8'h00) begin
            n_err++; $display("FAIL latency_early valid=%h exp=00", bus.digit_valid);
        end
        drive_edge(8'b11111100, 8'h01);
        n_vec++;
        if (bus.digits_out[3:0] !== 4'h0 || bus.digit_valid !== 8'h01 || bus.err !== 1'b0) begin
            n_err++; $display("FAIL latency_commit digit=%h valid=%h err=%b exp 0/01/0",
                              bus.digits_out[3:0], bus.digit_valid, bus.err);
        end
    endtask

    task automatic test_short_pulse();
        for (int e = 0; e < 4; e++) drive_edge(8'b01100000, 8'h02);
        for (int e = 0; e < 6; e++) drive_edge(8'b01100000, 8'h00);
        n_vec++;
        if (bus.digit_valid[1] !== 1'b0 || bus.digits_out[7:4] !== 4'hF) begin
            n_err++; $display("FAIL short_pulse valid1=%b digit1=%h exp 0/F",
                              bus.digit_valid[1], bus.digits_out[7:4]);
        end
    endtask

    task automatic test_scan_frame();
        int frames;
        frames = 0;
        apply_reset();
        for (int t = 0; t < N; t++) begin
            for (int j = 0; j < 6; j++) begin
                drive_edge({seg_tab[t+1], 1'b0}, N'(1) << t);
                if (bus.frame_done === 1'b1) frames++;
                if (t == N - 1 && j == 4) begin
                    n_vec++;
                    if (bus.frame_done !== 1'b1) begin
                        n_err++; $display("FAIL frame_coincident frame=%b exp=1", bus.frame_done);
                    end
                end
            end
            for (int j = 0; j < 2; j++) begin
                drive_edge({seg_tab[t+1], 1'b0}, '0);
                if (bus.frame_done === 1'b1) frames++;
            end
        end
        n_vec++;
        if (bus.digits_out !== 32'h87654321 || bus.digit_valid !== 8'hFF) begin
            n_err++; $display("FAIL scan_digits got=%h valid=%h exp=87654321/ff",
                              bus.digits_out, bus.digit_valid);
        end
        n_vec++;
        if (frames != 1) begin
            n_err++; $display("FAIL scan_frame_count got=%0d exp=1", frames);
        end
    endtask

    task automatic test_errors();
        int errs;
        errs = 0;
        for (int j = 0; j < 6; j++) begin
            drive_edge(8'b10010010, 8'h08);
            if (bus.err === 1'b1) errs++;
        end
        n_vec++;
        if (bus.digits_out[15:12] !== 4'hE || bus.digit_valid[3] !== 1'b1 || errs != 1) begin
            n_err++; $display("FAIL bad_pattern digit3=%h valid3=%b err_pulses=%0d exp E/1/1",
                              bus.digits_out[15:12], bus.digit_valid[3], errs);
        end
        errs = 0;
        for (int j = 0; j < 6; j++) begin
            drive_edge({seg_tab[2], 1'b0}, 8'h05);
            if (bus.err === 1'b1) errs++;
        end
        n_vec++;
        if (bus.digits_out !== 32'h8765E321 || errs != 1) begin
            n_err++; $display("FAIL multi_hot digits=%h err_pulses=%0d exp 8765e321/1",
                              bus.digits_out, errs);
        end
    endtask

    task automatic test_dp();
        for (int j = 0; j < 6; j++) drive_edge(8'b11111111, 8'h01);
        n_vec++;
        if (bus.digits_out[3:0] !== 4'h8 || bus.dp_out[0] !== DP_EN || bus.err !== 1'b0) begin
            n_err++; $display("FAIL dp_capture digit0=%h dp0=%b err=%b exp 8/%b/0",
                              bus.digits_out[3:0], bus.dp_out[0], bus.err, DP_EN);
        end
    endtask

    task automatic test_async_reset();
        for (int j = 0; j < 3; j++) drive_edge(8'b11111100, 8'h02);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (bus.digits_out !== {N{4'hF}} || bus.digit_valid !== '0 || bus.dp_out !== '0) begin
            n_err++; $display("FAIL async_reset digits=%h valid=%h dp=%h exp ffffffff/00/00",
                              bus.digits_out, bus.digit_valid, bus.dp_out);
        end
        rst = 1'b0;
        for (int j = 0; j < 4; j++) drive_edge(8'b11111100, 8'h02);
        n_vec++;
        if (bus.digit_valid !== 8'h00) begin
            n_err++; $display("FAIL post_reset_early valid=%h exp=00", bus.digit_valid);
        end
        drive_edge(8'b11111100, 8'h02);
        n_vec++;
        if (bus.digit_valid !== 8'h02 || bus.digits_out[7:4] !== 4'h0) begin
            n_err++; $display("FAIL post_reset_commit valid=%h digit1=%h exp 02/0",
                              bus.digit_valid, bus.digits_out[7:4]);
        end
    endtask

    task automatic test_random();
        logic [7:0]   seg;
        logic [N-1:0] sel;
        logic [4*N+3*N+1:0] act, exp;
        int r, hold, b0, b1;
        for (int ep = 0; ep < 300; ep++) begin
            r = $urandom_range(0, 11);
            if (r < 10)       seg = {seg_tab[r], 1'($urandom_range(0, 1))};
            else if (r == 10) seg = {7'b0, 1'($urandom_range(0, 1))};
            else              seg = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            if (r < 2) sel = '0;
            else if (r < 9) sel = N'(1) << $urandom_range(0, N - 1);
            else begin
                b0 = $urandom_range(0, N - 1);
                b1 = (b0 + $urandom_range(1, N - 1)) % N;
                sel = (N'(1) << b0) | (N'(1) << b1);
            end
            hold = $urandom_range(1, 8);
            for (int j = 0; j < hold; j++) begin
                drive_edge(seg, sel);
                act = {bus.digits_out, bus.digit_valid, bus.dp_out, bus.frame_done, bus.err};
                exp = {m_digits, m_valid, m_dp, m_frame, m_err};
                n_vec++;
                if (act !== exp) begin
                    n_err++; $display("FAIL random ep=%0d got=%h exp=%h", ep, act, exp);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.seg_in = 8'h00;
        bus.tub_sel_in = '0;
        model_reset();
        test_reset();
        test_commit_latency();
        test_short_pulse();
        test_scan_frame();
        test_errors();
        test_dp();
        test_async_reset();
        apply_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
